result_pack_buffer: RTL

- Write-result buffer downstream of the layer-2 MAC datapath and its controller.
- Takes signed MAC accumulator results one at a time, quantizes each to RES_W bits, and packs N_PACK results into one memory word.
- Raises full when the word is complete, then drives write data and write address to result memory when the controller asserts we.
- Owns the output write-address counter; the controller sequences it with ld / last / we / clr.

---
 rtl/result_pack_buffer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/result_pack_buffer.sv
// Quantizes signed accumulator results and packs N_PACK of them per memory word.
// Optional build macro RESULT_PACK_RELU_EN clamps negative results to zero first.
module result_pack_buffer #(
  parameter int ACC_W  = 20,
  parameter int RES_W  = 8,
  parameter int FRAC   = 4,
  parameter int N_PACK = 4,
  parameter int ADDR_W = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_adr,
  input  logic [ADDR_W-1:0]         base_adr,
  input  logic                      clr,
  input  logic                      ld,
  input  logic                      last,
  input  logic [ACC_W-1:0]          din,
  input  logic                      we,
  output logic                      full,
  output logic                      mem_we,
  output logic [N_PACK*RES_W-1:0]   mem_wdata,
  output logic [ADDR_W-1:0]         mem_waddr,
  output logic [ADDR_W-1:0]         words_written,
  output logic                      ovf
);

  localparam int CNT_W = $clog2(N_PACK + 1);
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((2 ** (RES_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Q_MIN = -Q_MAX - ACC_W'(1);

  typedef enum logic {S_FILL = 1'b0, S_FULL = 1'b1} state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [N_PACK*RES_W-1:0]  pack;
  logic [ADDR_W-1:0]        addr;
  logic [ADDR_W-1:0]        words;
  logic                     ovf_r;
  logic signed [ACC_W-1:0]  shifted;
  logic [RES_W-1:0]         q;
  logic                     wr_eff;
  logic                     last_slot;

  // Arithmetic shift to the result LSB, then saturate into RES_W signed range.
  always_comb begin
    shifted = $signed(din) >>> FRAC;
    if (shifted > Q_MAX)      q = Q_MAX[RES_W-1:0];
    else if (shifted < Q_MIN) q = Q_MIN[RES_W-1:0];
    else                      q = shifted[RES_W-1:0];
`ifdef RESULT_PACK_RELU_EN
    if (din[ACC_W-1]) q = '0;
`endif
  end

  assign last_slot = (cnt == CNT_W'(N_PACK - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: begin
        if (clr)                           state_nxt = S_FILL;
        else if (ld && (last_slot || last)) state_nxt = S_FULL;
        else if (last && cnt != '0)        state_nxt = S_FULL;
      end
      S_FULL: begin
        if (clr || we) state_nxt = S_FILL;
      end
      default: state_nxt = S_FILL;
    endcase
  end

  // clr overrides a coincident write strobe.
  always_comb begin
    full   = (state == S_FULL);
    wr_eff = (state == S_FULL) && we && !clr;
    mem_we = wr_eff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      pack  <= '0;
      addr  <= '0;
      words <= '0;
      ovf_r <= 1'b0;
    end else begin
      if (clr) begin
        cnt  <= '0;
        pack <= '0;
      end else if (state == S_FILL && ld) begin
        pack[int'(cnt)*RES_W +: RES_W] <= q;
        cnt <= cnt + 1'b1;
      end else if (wr_eff) begin
        cnt  <= '0;
        pack <= '0;
      end

      if (ld_adr)                               ovf_r <= 1'b0;
      else if (!clr && state == S_FULL && ld)   ovf_r <= 1'b1;

      if (ld_adr) begin
        addr  <= base_adr;
        words <= '0;
      end else if (wr_eff) begin
        addr  <= addr + 1'b1;
        words <= words + 1'b1;
      end
    end
  end

  assign mem_wdata     = pack;
  assign mem_waddr     = addr;
  assign words_written = words;
  assign ovf           = ovf_r;

endmodule
